// File: rtl/hc595_pkg.sv
// Shared types and constants for the 74HC595 serial driver.
package hc595_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOW   = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  localparam int DATA_W_DEFAULT  = 8;
  localparam int CLK_DIV_DEFAULT = 4;

  // Counter width for a 0..div-1 phase counter; never narrower than one bit.
  function automatic int phase_cnt_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/hc595_if.sv
// Controller-to-driver enable/ready handshake carrying the parallel word.
interface hc595_if
  import hc595_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
);
  logic [DATA_W-1:0] i_data;
  logic              i_enable;
  logic              o_ready;

  modport master (output i_data, output i_enable, input o_ready);
  modport slave  (input i_data, input i_enable, output o_ready);
endinterface

// File: rtl/hc595_tick.sv
// Phase counter 0..CLK_DIV-1 with synchronous clear; o_tick is high in the
// last count of every phase.
module hc595_tick
  import hc595_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_tick
);
  localparam int            CW   = phase_cnt_w(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);
endmodule

// File: rtl/hc595_shifter.sv
// Shifts a DATA_W word MSB-first onto SER/SRCLK, then pulses RCLK; ready is low
// for (2*DATA_W+1)*CLK_DIV cycles. Optional QH' readback under HC595_READBACK_EN.
module hc595_shifter
  import hc595_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  hc595_if.slave                       bus,
  output logic                         o_ser,
  output logic                         o_srclk,
  output logic                         o_rclk,
  output logic [$clog2(DATA_W+1)-1:0]  o_busy_cnt
`ifdef HC595_READBACK_EN
  ,
  input  logic                         i_qh,
  output logic [DATA_W-1:0]            o_rdata,
  output logic                         o_rvalid
`endif
);
  localparam int BCW = $clog2(DATA_W + 1);

  state_t            r_state;
  logic [DATA_W-1:0] r_sr;
  logic              w_accept;
  logic              w_tick;

  assign w_accept = (r_state == ST_IDLE) && bus.i_enable;

  hc595_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_accept),
    .o_tick  (w_tick)
  );

  // SER is the shift register MSB; shifting on every SRCLK fall leaves zeros
  // behind, so SER is low again once the last bit has been clocked out.
  assign o_ser = r_sr[DATA_W-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_sr        <= '0;
      bus.o_ready <= 1'b1;
      o_srclk     <= 1'b0;
      o_rclk      <= 1'b0;
      o_busy_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_enable) begin
            r_sr        <= bus.i_data;
            bus.o_ready <= 1'b0;
            o_busy_cnt  <= BCW'(DATA_W);
            r_state     <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (w_tick) begin
            o_srclk <= 1'b1;
            r_state <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (w_tick) begin
            o_srclk    <= 1'b0;
            o_busy_cnt <= o_busy_cnt - BCW'(1);
            r_sr       <= {r_sr[DATA_W-2:0], 1'b0};
            if (o_busy_cnt > BCW'(1)) begin
              r_state <= ST_LOW;
            end else begin
              o_rclk  <= 1'b1;
              r_state <= ST_LATCH;
            end
          end
        end
        ST_LATCH: begin
          if (w_tick) begin
            o_rclk      <= 1'b0;
            bus.o_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef HC595_READBACK_EN
  logic              r_qh_meta;
  logic              r_qh_sync;
  logic [DATA_W-1:0] r_rsh;

  // QH' is captured at the end of each LOW phase, before the next SRCLK rise
  // moves the chain, so the assembled word is the one resident before the transfer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_qh_meta <= 1'b0;
      r_qh_sync <= 1'b0;
      r_rsh     <= '0;
      o_rdata   <= '0;
      o_rvalid  <= 1'b0;
    end else begin
      r_qh_meta <= i_qh;
      r_qh_sync <= r_qh_meta;
      o_rvalid  <= 1'b0;
      if ((r_state == ST_LOW) && w_tick) begin
        r_rsh <= {r_rsh[DATA_W-2:0], r_qh_sync};
      end
      if ((r_state == ST_LATCH) && w_tick) begin
        o_rdata  <= r_rsh;
        o_rvalid <= 1'b1;
      end
    end
  end
`endif
endmodule
